store_byte_queue: RTL and testbench

STORE_BYTE_QUEUE -- requirements
Module: store_byte_queue

---
 rtl/store_byte_queue.sv | 134 +++++++++++++
 tb/tb_store_byte_queue.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_byte_queue.sv
// Store queue that lane-positions byte/half/word/double stores into aligned
// memory words, optionally coalescing into the youngest entry, and drains in order.
module store_byte_queue #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 4,
    parameter int MERGE_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [2:0]                req_op,
    input  logic [31:0]               req_addr,
    input  logic [DATA_W-1:0]         req_wdata,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic [31:0]               mem_addr,
    output logic [DATA_W/8-1:0]       mem_byteen,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      align_err,
    output logic [$clog2(DEPTH):0]    count
);

    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]       r_addr [DEPTH];
    logic [NB-1:0]     r_be   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_align_err;

    logic [LW-1:0]     w_lane;
    logic [NB-1:0]     w_be;
    logic              w_ok;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_data;
    logic [31:0]       w_addr_al;
    logic [PW-1:0]     w_young;
    logic              w_deq;
    logic              w_merge;
    logic              w_accept;
    logic              w_push;
    logic              w_mrg;

    always_comb begin
        w_lane = req_addr[LW-1:0];
        w_be   = '0;
        w_ok   = 1'b0;
        case (req_op)
            3'b010: begin
                w_be = NB'(1) << w_lane;
                w_ok = 1'b1;
            end
            3'b011: begin
                w_be = NB'(3) << w_lane;
                w_ok = ~req_addr[0];
            end
            3'b001: begin
                w_be = NB'(15) << w_lane;
                w_ok = (req_addr[1:0] == 2'b00);
            end
            3'b100: begin
                w_be = '1;
                w_ok = (DATA_W == 64) && (req_addr[2:0] == 3'b000);
            end
            default: ;
        endcase
    end

    // Disabled lanes are zeroed so a fresh entry carries no stale upper data.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NB; i++) begin
            w_mask[8*i +: 8] = {8{w_be[i]}};
        end
    end

    assign w_data    = (req_wdata << {w_lane, 3'b000}) & w_mask;
    assign w_addr_al = {req_addr[31:LW], {LW{1'b0}}};
    assign w_young   = r_tail - PW'(1);

    assign mem_valid  = (r_count != '0);
    assign mem_addr   = r_addr[r_head];
    assign mem_byteen = r_be[r_head];
    assign mem_wdata  = r_data[r_head];
    assign align_err  = r_align_err;
    assign count      = r_count;

    assign w_deq   = mem_valid & mem_ready;
    assign w_merge = (MERGE_EN != 0) && (r_count != '0) &&
                     (w_addr_al == r_addr[w_young]) &&
                     !(w_deq && (w_young == r_head));

    assign req_ready = !reset || (r_count < CW'(DEPTH)) || w_merge;
    assign w_accept  = req_valid & req_ready;
    assign w_push    = w_accept & w_ok & ~w_merge;
    assign w_mrg     = w_accept & w_ok & w_merge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_align_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_be[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_align_err <= w_accept & ~w_ok;
            if (w_push) begin
                r_addr[r_tail] <= w_addr_al;
                r_be[r_tail]   <= w_be;
                r_data[r_tail] <= w_data;
                r_tail         <= r_tail + PW'(1);
            end
            if (w_mrg) begin
                r_be[w_young]   <= r_be[w_young] | w_be;
                r_data[w_young] <= (r_data[w_young] & ~w_mask) | w_data;
            end
            if (w_deq) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_deq);
        end
    end

endmodule

// File: tb/tb_store_byte_queue.sv
// Scoreboard bench for store_byte_queue: 32-bit and 64-bit instances, expected
// drained entries queued by the stimulus and checked by per-instance monitors.
module tb_store_byte_queue;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic        rv32, rr32, mv32, mr32, ae32;
    logic [2:0]  op32, cnt32;
    logic [31:0] ad32, ma32, wd32, md32;
    logic [3:0]  be32;

    logic        rv64, rr64, mv64, mr64, ae64;
    logic [2:0]  op64, cnt64;
    logic [31:0] ad64, ma64;
    logic [63:0] wd64, md64;
    logic [7:0]  be64;

    store_byte_queue #(.DATA_W(32), .DEPTH(4), .MERGE_EN(1)) dut32 (
        .clk(clk), .reset(reset),
        .req_valid(rv32), .req_ready(rr32), .req_op(op32), .req_addr(ad32), .req_wdata(wd32),
        .mem_valid(mv32), .mem_ready(mr32), .mem_addr(ma32), .mem_byteen(be32), .mem_wdata(md32),
        .align_err(ae32), .count(cnt32)
    );

    store_byte_queue #(.DATA_W(64), .DEPTH(4), .MERGE_EN(1)) dut64 (
        .clk(clk), .reset(reset),
        .req_valid(rv64), .req_ready(rr64), .req_op(op64), .req_addr(ad64), .req_wdata(wd64),
        .mem_valid(mv64), .mem_ready(mr64), .mem_addr(ma64), .mem_byteen(be64), .mem_wdata(md64),
        .align_err(ae64), .count(cnt64)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] data;
    } exp_t;

    exp_t sb32[$];
    exp_t sb64[$];
    exp_t m32e, m64e;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (reset && mv32 && mr32) begin
            if (sb32.size() == 0) begin
                tests++; fails++;
                $display("FAIL deq32_unexpected: got addr %h expected no entry", ma32);
            end else begin
                m32e = sb32.pop_front();
                chk("deq32_addr", ma32, m32e.addr);
                chk("deq32_be",   be32, m32e.be);
                chk("deq32_data", md32, m32e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (reset && mv64 && mr64) begin
            if (sb64.size() == 0) begin
                tests++; fails++;
                $display("FAIL deq64_unexpected: got addr %h expected no entry", ma64);
            end else begin
                m64e = sb64.pop_front();
                chk("deq64_addr", ma64, m64e.addr);
                chk("deq64_be",   be64, m64e.be);
                chk("deq64_data", md64, m64e.data);
            end
        end
    end

    task automatic send(input bit w64, input logic [2:0] op, input logic [31:0] a, input logic [63:0] d);
        int n;
        n = 0;
        if (w64) begin
            rv64 = 1'b1; op64 = op; ad64 = a; wd64 = d;
        end else begin
            rv32 = 1'b1; op32 = op; ad32 = a; wd32 = d[31:0];
        end
        @(negedge clk);
        while (!(w64 ? rr64 : rr32) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!(w64 ? rr64 : rr32)) begin
            tests++; fails++;
            $display("FAIL send_timeout: req_ready got 0 expected 1 (addr %h)", a);
        end
        @(posedge clk); #1;
        rv32 = 1'b0;
        rv64 = 1'b0;
    endtask

    task automatic drain(input bit w64);
        int n;
        n = 0;
        if (w64) mr64 = 1'b1; else mr32 = 1'b1;
        while ((w64 ? cnt64 : cnt32) != 3'd0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", w64 ? cnt64 : cnt32, 0);
        mr32 = 1'b0;
        mr64 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck, expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        rv32 = 0; op32 = 0; ad32 = 0; wd32 = 0; mr32 = 0;
        rv64 = 0; op64 = 0; ad64 = 0; wd64 = 0; mr64 = 0;
        #2;
        chk("rst_ready32", rr32, 1);
        chk("rst_ready64", rr64, 1);
        chk("rst_mvalid32", mv32, 0);
        chk("rst_count32", cnt32, 0);
        chk("rst_aerr32", ae32, 0);

        // A request held during reset must leave no trace.
        rv32 = 1'b1; op32 = 3'b010; ad32 = 32'h0; wd32 = 32'h5A;
        @(posedge clk); #1;
        @(posedge clk); #3;
        reset = 1'b1;
        rv32 = 1'b0;
        @(posedge clk); #1;
        chk("rst_ignored_cnt", cnt32, 0);
        chk("rst_ignored_mv", mv32, 0);

        // sb lane 3
        sb32.push_back('{32'h10, 8'h08, 64'hAB000000});
        send(0, 3'b010, 32'h13, 64'hAB);
        chk("sb_count", cnt32, 1);
        chk("sb_mvalid", mv32, 1);
        chk("sb_addr", ma32, 32'h10);
        chk("sb_be", be32, 4'b1000);
        chk("sb_data", md32, 32'hAB000000);
        drain(0);

        // sb then sh to same word coalesce
        sb32.push_back('{32'h20, 8'h0D, 64'h33440011});
        send(0, 3'b010, 32'h20, 64'h11);
        send(0, 3'b011, 32'h22, 64'h3344);
        chk("merge_count", cnt32, 1);
        chk("merge_be", be32, 4'b1101);
        chk("merge_data", md32, 32'h33440011);

        // rejected requests
        send(0, 3'b001, 32'h6, 64'h55);
        chk("sw_mis_aerr", ae32, 1);
        chk("sw_mis_count", cnt32, 1);
        chk("sw_mis_mvalid", mv32, 1);
        @(posedge clk); #1;
        chk("aerr_pulse_end", ae32, 0);
        send(0, 3'b111, 32'h20, 64'h99);
        chk("bad_op_aerr", ae32, 1);
        send(0, 3'b100, 32'h20, 64'h99);
        chk("sd_on32_aerr", ae32, 1);
        send(0, 3'b011, 32'h21, 64'hFFFF);
        chk("sh_odd_aerr", ae32, 1);
        chk("sh_odd_count", cnt32, 1);
        chk("sh_odd_be", be32, 4'b1101);
        chk("sh_odd_data", md32, 32'h33440011);
        drain(0);

        // fill, merge while full, then stall a new word until memory drains
        sb32.push_back('{32'h40, 8'h0F, 64'h11111111});
        sb32.push_back('{32'h44, 8'h0F, 64'h22222222});
        sb32.push_back('{32'h48, 8'h0F, 64'h33333333});
        sb32.push_back('{32'h4C, 8'h09, 64'hAA000044});
        sb32.push_back('{32'h50, 8'h0F, 64'h55555555});
        send(0, 3'b001, 32'h40, 64'h11111111);
        send(0, 3'b001, 32'h44, 64'h22222222);
        send(0, 3'b001, 32'h48, 64'h33333333);
        send(0, 3'b010, 32'h4C, 64'h44);
        chk("full_count", cnt32, 4);
        ad32 = 32'h50;
        #1;
        chk("full_ready", rr32, 0);
        send(0, 3'b010, 32'h4F, 64'hAA);
        chk("full_merge_count", cnt32, 4);
        fork
            send(0, 3'b001, 32'h50, 64'h55555555);
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_count", cnt32, 4);
                chk("stall_ready", rr32, 0);
                mr32 = 1'b1;
            end
        join
        drain(0);

        // no merge into a head that is leaving this cycle
        sb32.push_back('{32'h60, 8'h01, 64'h01});
        sb32.push_back('{32'h60, 8'h02, 64'h0200});
        mr32 = 1'b1;
        send(0, 3'b010, 32'h60, 64'h01);
        send(0, 3'b010, 32'h61, 64'h02);
        chk("deq_nomerge_count", cnt32, 1);
        drain(0);

        // 64-bit lanes
        sb64.push_back('{32'h100, 8'hF0, 64'hDEADBEEF_00000000});
        send(1, 3'b001, 32'h104, 64'hDEADBEEF);
        chk("sw64_count", cnt64, 1);
        chk("sw64_addr", ma64, 32'h100);
        chk("sw64_be", be64, 8'hF0);
        chk("sw64_data", md64, 64'hDEADBEEF_00000000);
        send(1, 3'b100, 32'h104, 64'h1);
        chk("sd64_mis_aerr", ae64, 1);
        chk("sd64_mis_count", cnt64, 1);
        sb64.push_back('{32'h108, 8'hFF, 64'h01234567_BEEFCDEF});
        send(1, 3'b100, 32'h108, 64'h01234567_89ABCDEF);
        send(1, 3'b011, 32'h10A, 64'hBEEF);
        chk("sd64_count", cnt64, 2);
        drain(1);

        // reset while full and draining
        send(0, 3'b001, 32'h80, 64'h80808080);
        send(0, 3'b001, 32'h84, 64'h84848484);
        send(0, 3'b001, 32'h88, 64'h88888888);
        send(0, 3'b001, 32'h8C, 64'h8C8C8C8C);
        chk("pre_rst_count", cnt32, 4);
        mr32 = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_mvalid", mv32, 0);
        chk("mid_rst_count", cnt32, 0);
        chk("mid_rst_ready", rr32, 1);
        @(posedge clk); #3;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_mvalid", mv32, 0);
        chk("post_rst_count", cnt32, 0);
        sb32.push_back('{32'h90, 8'h02, 64'h7700});
        send(0, 3'b010, 32'h91, 64'h77);
        drain(0);

        chk("sb32_left", sb32.size(), 0);
        chk("sb64_left", sb64.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
